// File: rtl/fpga_template_pkg.sv
// Shared widths, LED scale constants and peak-hold state encoding for the VU meter.
package fpga_template_pkg;

    localparam int SAMPLE_W       = 24;
    localparam int LED_W          = 6;
    localparam int LEVEL_BASE_EXP = 17;
    localparam int ENV_W          = SAMPLE_W - 1;
    localparam int PEAK_W         = $clog2(LED_W);

    typedef enum logic [1:0] {
        HOLD_IDLE,
        HOLDING,
        FALLING
    } hold_state_e;

    // Index of the highest lit segment; 0 when the bar is empty.
    function automatic logic [PEAK_W-1:0] top_index(input logic [LED_W-1:0] therm);
        logic [PEAK_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < LED_W; k++) begin
            if (therm[k]) idx = PEAK_W'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/vu_meter_if.sv
// Sample input / LED bar output bundle between the I2S capture stage and the VU meter.
interface vu_meter_if
    import fpga_template_pkg::*;
();

    logic signed [SAMPLE_W-1:0] sample_i;
    logic                       sample_valid_i;
    logic                       sample_ready_o;
    logic [LED_W-1:0]           level_o;
    logic                       level_valid_o;
    logic [ENV_W-1:0]           env_o;

    modport master (
        output sample_i,
        output sample_valid_i,
        input  sample_ready_o,
        input  level_o,
        input  level_valid_o,
        input  env_o
    );

    modport slave (
        input  sample_i,
        input  sample_valid_i,
        output sample_ready_o,
        output level_o,
        output level_valid_o,
        output env_o
    );

endinterface

// File: rtl/vu_level_encode.sv
// Envelope to thermometer-coded LED bar: segment k lights at env >= 2^(LEVEL_BASE_EXP+k).
module vu_level_encode
    import fpga_template_pkg::*;
(
    input  logic [ENV_W-1:0] i_env,
    output logic [LED_W-1:0] o_therm
);

    always_comb begin
        o_therm = '0;
        for (int k = 0; k < LED_W; k++) begin
            o_therm[k] = (i_env >= (ENV_W'(1) << (LEVEL_BASE_EXP + k)));
        end
    end

endmodule

// File: rtl/vu_meter.sv
// Peak-envelope VU meter: |sample| -> decaying envelope -> registered LED bar.
// Optional peak-hold marker built only when VU_PEAK_HOLD_EN is defined.
module vu_meter
    import fpga_template_pkg::*;
#(
    parameter int DECAY_CYCLES = 270000,
    parameter int DECAY_SHIFT  = 4,
    parameter int HOLD_CYCLES  = 13500000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    vu_meter_if.slave  bus
);

    localparam int DCNT_W = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;

    if (DECAY_CYCLES < 1 || DECAY_SHIFT < 1 || HOLD_CYCLES < 1) begin : g_param_check
        $error("vu_meter: DECAY_CYCLES, DECAY_SHIFT and HOLD_CYCLES must be positive");
    end

    function automatic logic [ENV_W-1:0] abs_sat(input logic signed [SAMPLE_W-1:0] s);
        if (s == {1'b1, {(SAMPLE_W-1){1'b0}}}) return '1;
        return s[SAMPLE_W-1] ? ENV_W'(-s) : ENV_W'(s);
    endfunction

    // env=1 would never leave the floor through the shift alone, so it is forced to 0.
    function automatic logic [ENV_W-1:0] decay_step(input logic [ENV_W-1:0] env);
        if (env == ENV_W'(1)) return '0;
        return env - (env >> DECAY_SHIFT);
    endfunction

    logic [DCNT_W-1:0] r_dcnt;
    logic              w_tick;
    logic              w_accept;
    logic [ENV_W-1:0]  r_mag_p1;
    logic              r_vld_p1;
    logic [ENV_W-1:0]  w_decayed;
    logic [ENV_W-1:0]  w_env_next;
    logic [ENV_W-1:0]  r_env_p2;
    logic              r_vld_p2;
    logic [LED_W-1:0]  w_therm;
    logic [LED_W-1:0]  w_level_next;
    logic [LED_W-1:0]  r_level_p3;
    logic              r_vld_p3;

    assign bus.sample_ready_o = ~rst_i;
    assign w_accept           = bus.sample_valid_i & bus.sample_ready_o;
    assign w_tick             = (r_dcnt == DCNT_W'(DECAY_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) r_dcnt <= '0;
        else       r_dcnt <= w_tick ? '0 : r_dcnt + 1'b1;
    end

    // Stage 1: saturating magnitude
    always_ff @(posedge clk_i) begin
        r_mag_p1 <= abs_sat(bus.sample_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_vld_p1 <= 1'b0;
        else       r_vld_p1 <= w_accept;
    end

    // Stage 2: decay first, then peak compare, so a fresh sample is never decayed on arrival
    always_comb begin
        w_decayed  = w_tick ? decay_step(r_env_p2) : r_env_p2;
        w_env_next = (r_vld_p1 && (r_mag_p1 > w_decayed)) ? r_mag_p1 : w_decayed;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_env_p2 <= '0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_env_p2 <= w_env_next;
            r_vld_p2 <= r_vld_p1;
        end
    end

    vu_level_encode u_encode (
        .i_env   (r_env_p2),
        .o_therm (w_therm)
    );

`ifdef VU_PEAK_HOLD_EN
    localparam int HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    hold_state_e       r_hold_st;
    hold_state_e       w_hold_st_next;
    logic [PEAK_W-1:0] r_peak;
    logic [PEAK_W-1:0] w_peak_next;
    logic [HCNT_W-1:0] r_hcnt;
    logic [HCNT_W-1:0] w_hcnt_next;
    logic [PEAK_W-1:0] w_top;
    logic              w_lit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hold_st <= HOLD_IDLE;
            r_peak    <= '0;
            r_hcnt    <= '0;
        end else begin
            r_hold_st <= w_hold_st_next;
            r_peak    <= w_peak_next;
            r_hcnt    <= w_hcnt_next;
        end
    end

    always_comb begin
        w_hold_st_next = r_hold_st;
        w_peak_next    = r_peak;
        w_hcnt_next    = r_hcnt;
        w_lit          = |w_therm;
        w_top          = top_index(w_therm);
        if (w_lit && (r_hold_st == HOLD_IDLE || w_top > r_peak)) begin
            w_hold_st_next = HOLDING;
            w_peak_next    = w_top;
            w_hcnt_next    = '0;
        end else begin
            case (r_hold_st)
                HOLDING: begin
                    if (r_hcnt == HCNT_W'(HOLD_CYCLES - 1)) begin
                        w_hold_st_next = FALLING;
                        w_hcnt_next    = '0;
                    end else begin
                        w_hcnt_next = r_hcnt + 1'b1;
                    end
                end
                FALLING: begin
                    if (w_lit && w_top == r_peak) begin
                        w_hold_st_next = HOLDING;
                        w_hcnt_next    = '0;
                    end else if (w_tick) begin
                        if (r_peak == '0) w_hold_st_next = HOLD_IDLE;
                        else              w_peak_next    = r_peak - 1'b1;
                    end
                end
                default: ;
            endcase
        end
        w_level_next = w_therm |
                       ((w_hold_st_next != HOLD_IDLE) ? (LED_W'(1) << w_peak_next) : '0);
    end
`else
    assign w_level_next = w_therm;
`endif

    // Stage 3: registered LED bar
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_level_p3 <= '0;
            r_vld_p3   <= 1'b0;
        end else begin
            r_level_p3 <= w_level_next;
            r_vld_p3   <= r_vld_p2;
        end
    end

    assign bus.env_o         = r_env_p2;
    assign bus.level_o       = r_level_p3;
    assign bus.level_valid_o = r_vld_p3;

endmodule

// File: tb/tb_vu_meter.sv
// Directed bench for vu_meter with DECAY_CYCLES=8, DECAY_SHIFT=4, HOLD_CYCLES=20.
module tb_vu_meter;

    localparam int DC = 8;
    localparam int DS = 4;
    localparam int HC = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vu_meter_if bus ();

    vu_meter #(
        .DECAY_CYCLES (DC),
        .DECAY_SHIFT  (DS),
        .HOLD_CYCLES  (HC)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [23:0] sample;
        int          env;
        logic [5:0]  level;
    } vec_t;

    typedef struct {
        logic [23:0] sample;
        int          env_after_tick;
    } floor_t;

    vec_t   vecs [10];
    floor_t flr  [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [23:0] s);
        bus.sample_valid_i = v;
        bus.sample_i       = s;
    endtask

    // After return the bench is in cycle 0: the first cycle with rst low.
    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 24'h0);
        repeat (3) next();
        chk("rst_ready", 32'(bus.sample_ready_o), 0);
        chk("rst_env",   32'(bus.env_o), 0);
        chk("rst_level", 32'(bus.level_o), 0);
        chk("rst_lv",    32'(bus.level_valid_o), 0);
        rst = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{24'h400000, 4194304, 6'b111111};
        vecs[1] = '{24'h800000, 8388607, 6'b111111};
        vecs[2] = '{24'h020000,  131072, 6'b000001};
        vecs[3] = '{24'hFE0000,  131072, 6'b000001};
        vecs[4] = '{24'h01FFFF,  131071, 6'b000000};
        vecs[5] = '{24'h0FFFFF, 1048575, 6'b000111};
        vecs[6] = '{24'h7FFFFF, 8388607, 6'b111111};
        vecs[7] = '{24'hFFFFFF,       1, 6'b000000};
        vecs[8] = '{24'h000000,       0, 6'b000000};
        vecs[9] = '{24'h200000, 2097152, 6'b011111};

        flr[0] = '{24'h000001,  0};
        flr[1] = '{24'h00000F, 15};
        flr[2] = '{24'h000010, 15};
        flr[3] = '{24'h000011, 16};
        flr[4] = '{24'h000020, 30};
        flr[5] = '{24'hFFFFF1, 15};

        drive(1'b0, 24'h0);

        // single accepted sample: latency, magnitude and thermometer
        for (int i = 0; i < 10; i++) begin
            do_reset();
            for (int c = 0; c < 5; c++) begin
                drive(c == 0, vecs[i].sample);
                #1;
                case (c)
                    0: chk($sformatf("tbl%0d_ready", i), 32'(bus.sample_ready_o), 1);
                    1: chk($sformatf("tbl%0d_lv_n1", i), 32'(bus.level_valid_o), 0);
                    2: begin
                        chk($sformatf("tbl%0d_env", i), 32'(bus.env_o), 32'(vecs[i].env));
                        chk($sformatf("tbl%0d_lv_n2", i), 32'(bus.level_valid_o), 0);
                    end
                    3: begin
                        chk($sformatf("tbl%0d_lv_n3", i), 32'(bus.level_valid_o), 1);
                        chk($sformatf("tbl%0d_level", i), 32'(bus.level_o), 32'(vecs[i].level));
                    end
                    default: chk($sformatf("tbl%0d_lv_n4", i), 32'(bus.level_valid_o), 0);
                endcase
                next();
            end
        end

        // decay floor: first tick lands in cycle 7, visible in cycle 8
        for (int i = 0; i < 6; i++) begin
            do_reset();
            for (int c = 0; c <= 8; c++) begin
                drive(c == 0, flr[i].sample);
                #1;
                if (c == 8) chk($sformatf("floor%0d_env", i), 32'(bus.env_o), 32'(flr[i].env_after_tick));
                next();
            end
        end

        // 0x020000 then silence: bar segment 0 drops at the first tick, without a valid pulse
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            drive(c == 0, 24'h020000);
            #1;
            case (c)
                7: begin
                    chk("dec_env_pre",   32'(bus.env_o), 131072);
                    chk("dec_level_pre", 32'(bus.level_o), 32'(6'b000001));
                end
                8: begin
                    chk("dec_env_tick",  32'(bus.env_o), 122880);
                    chk("dec_level_reg", 32'(bus.level_o), 32'(6'b000001));
                end
                9: begin
                    chk("dec_level_post", 32'(bus.level_o), 0);
                    chk("dec_lv_post",    32'(bus.level_valid_o), 0);
                end
                default: ;
            endcase
            next();
        end

        // 0x100000 arriving in stage 1 on the tick cycle against env=0x100000
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            drive(c == 0 || c == 6, 24'h100000);
            #1;
            case (c)
                7:  chk("coin_env_pre",  32'(bus.env_o), 1048576);
                8:  chk("coin_env_tick", 32'(bus.env_o), 1048576);
                9: begin
                    chk("coin_lv",    32'(bus.level_valid_o), 1);
                    chk("coin_level", 32'(bus.level_o), 32'(6'b001111));
                end
                16: chk("coin_env_decay", 32'(bus.env_o), 983040);
                default: ;
            endcase
            next();
        end

        // back-to-back samples, one per cycle
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            case (c)
                0: drive(1'b1, 24'h010000);
                1: drive(1'b1, 24'h020000);
                2: drive(1'b1, 24'h040000);
                3: drive(1'b1, 24'h080000);
                default: drive(1'b0, 24'h0);
            endcase
            #1;
            if (c <= 3) chk($sformatf("b2b_ready_c%0d", c), 32'(bus.sample_ready_o), 1);
            case (c)
                2: chk("b2b_env_c2", 32'(bus.env_o), 65536);
                3: begin
                    chk("b2b_env_c3", 32'(bus.env_o), 131072);
                    chk("b2b_lv_c3", 32'(bus.level_valid_o), 1);
                    chk("b2b_level_c3", 32'(bus.level_o), 32'(6'b000000));
                end
                4: begin
                    chk("b2b_env_c4", 32'(bus.env_o), 262144);
                    chk("b2b_lv_c4", 32'(bus.level_valid_o), 1);
                    chk("b2b_level_c4", 32'(bus.level_o), 32'(6'b000001));
                end
                5: begin
                    chk("b2b_env_c5", 32'(bus.env_o), 524288);
                    chk("b2b_lv_c5", 32'(bus.level_valid_o), 1);
                    chk("b2b_level_c5", 32'(bus.level_o), 32'(6'b000011));
                end
                6: begin
                    chk("b2b_lv_c6", 32'(bus.level_valid_o), 1);
                    chk("b2b_level_c6", 32'(bus.level_o), 32'(6'b000111));
                end
                7: chk("b2b_lv_c7", 32'(bus.level_valid_o), 0);
                default: ;
            endcase
            next();
        end

        // one-cycle reset with two samples in flight, then a sample right after reset
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            rst = (c == 2);
            case (c)
                0, 1: drive(1'b1, 24'h400000);
                3:    drive(1'b1, 24'h020000);
                default: drive(1'b0, 24'h0);
            endcase
            #1;
            case (c)
                2: begin
                    chk("flush_ready_in_rst", 32'(bus.sample_ready_o), 0);
                    chk("flush_env_pre", 32'(bus.env_o), 4194304);
                end
                3: begin
                    chk("flush_env",   32'(bus.env_o), 0);
                    chk("flush_level", 32'(bus.level_o), 0);
                    chk("flush_lv_c3", 32'(bus.level_valid_o), 0);
                    chk("flush_ready", 32'(bus.sample_ready_o), 1);
                end
                4: chk("flush_lv_c4", 32'(bus.level_valid_o), 0);
                5: begin
                    chk("flush_lv_c5", 32'(bus.level_valid_o), 0);
                    chk("post_rst_env", 32'(bus.env_o), 131072);
                end
                6: begin
                    chk("post_rst_lv", 32'(bus.level_valid_o), 1);
                    chk("post_rst_level", 32'(bus.level_o), 32'(6'b000001));
                end
                7: chk("post_rst_lv_end", 32'(bus.level_valid_o), 0);
                default: ;
            endcase
            next();
        end
        rst = 1'b0;

`ifdef VU_PEAK_HOLD_EN
        // peak hold: bit 5 held after the envelope falls below 2^22, then a stepwise drain to idle
        begin
            int n;
            int prev_hi;
            int hi;
            do_reset();
            for (int c = 0; c <= 22; c++) begin
                drive(c == 0, 24'h400000);
                #1;
                if (c >= 3) chk($sformatf("hold_bit5_c%0d", c), 32'(bus.level_o[5]), 1);
                next();
            end
            prev_hi = 5;
            n = 0;
            while (bus.level_o != 6'b0 && n < 3000) begin
                hi = -1;
                for (int k = 0; k < 6; k++) if (bus.level_o[k]) hi = k;
                if (hi != prev_hi) chk("hold_step_size", 32'(prev_hi - hi), 1);
                prev_hi = hi;
                next();
                n++;
            end
            chk("hold_drain_done", 32'(n < 3000), 1);
            for (int c = 0; c < 10; c++) begin
                #1;
                chk("hold_idle_level", 32'(bus.level_o), 0);
                next();
            end
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
